calc_ctrl_fsm: RTL and testbench
================================

# calc_ctrl_fsm

Parametrised calculator control FSM for the FPGA calculator, DIGITS BCD-nibble operands wide. It replaces edge-triggered keypad capture with a synchronous key strobe and drives the ALU through a start/done handshake with timeout. It supports operator chaining, repeat-equals, clear-entry vs all-clear, and an error state. It sits between the keypad decoder and the ALU/display driver.

## Interface
- DIGITS, 4, operand digits; W = 4*DIGITS.
- TIMEOUT, 64, maximum CALC cycles to wait for alu_done before declaring error.

- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- key_valid  in  1  one-cycle strobe, key_code valid, synchronous to clk.
- key_code  in  4  0–9 digits, 0xA equal, 0xB AC, 0xC plus, 0xD minus, 0xE mult, 0xF div.
- alu_res  in  W  ALU result, valid with alu_done.
- alu_done  in  1  one-cycle ALU completion strobe.
- alu_err  in  1  qualifies alu_done: overflow or divide-by-zero.
- alu_a  out  W  operand A, held stable while busy.
- alu_b  out  W  operand B, held stable while busy.
- alu_op  out  4  operator code (0xC–0xF), held stable while busy.
- alu_start  out  1  one-cycle request pulse.
- display  out  W  registered value to show.
- disp_err  out  1  high in ERROR state.
- busy  out  1  high in CALC; keys ignored.

## Operation
- Registers:
  - num1, num2, res (W bits each).
  - cnt1, cnt2 (digit counters, 0..DIGITS).
  - op, pend_op, chain flag, timeout counter.
- Digit entry:
  - X = {X[W-5:0], key}, cnt++.
  - Ignored when cnt == DIGITS.
  - A '0' key while X == 0 leaves cnt at 0.
- States: N1, N2, CALC, SHOW, ERROR.
- Reset: state N1, every register and output 0.
- N1:
  - digit: enters into num1.
  - operator: op = key, num2 = 0, cnt2 = 0, go to N2.
  - AC: num1 = 0, cnt1 = 0.
  - equal: ignored.
- N2:
  - digit: enters into num2.
  - operator with cnt2 == 0: replaces op.
  - operator with cnt2 > 0: pend_op = key, chain = 1, go to CALC.
  - equal with cnt2 > 0: chain = 0, go to CALC.
  - equal with cnt2 == 0: ignored.
  - AC with cnt2 > 0: clears num2/cnt2 (clear entry).
  - AC with cnt2 == 0: clears all, go to N1.
- CALC:
  - On entry: alu_a = num1, alu_b = num2, alu_op = op, alu_start pulses.
  - alu_done with alu_err: go to ERROR.
  - alu_done, chain = 1: num1 = alu_res, op = pend_op, num2 = 0, cnt2 = 0, go to N2.
  - alu_done, chain = 0: res = alu_res, go to SHOW.
  - Timeout counter reaches TIMEOUT without alu_done: go to ERROR.
- SHOW:
  - digit: num1 = key, cnt1 = (key != 0), num2 = 0, go to N1.
  - operator: num1 = res, op = key, num2 = 0, cnt2 = 0, go to N2.
  - equal: num1 = res, repeat op with the same num2, go to CALC with chain = 0.
  - AC: clears all, go to N1.
- ERROR:
  - Only AC is accepted: clears all, go to N1.
  - All other keys are ignored.
- Display source by state:
  - N1: num1.
  - N2: num2 if cnt2 > 0, else num1.
  - CALC: holds the previous value.
  - SHOW: res.
  - ERROR: 0 with disp_err = 1.

## Timing
- A key is sampled on the edge where key_valid = 1. State and registers update on that edge. display updates on the following edge, so display latency is 2 edges.
- Entering CALC:
  - alu_start = 1 for exactly the cycle after the key edge.
  - busy rises on the same edge as alu_start.
  - alu_a, alu_b and alu_op change only on that same edge.
- alu_done is sampled only in CALC cycles after the alu_start cycle. Minimum ALU latency is 1.
- busy falls on the edge that samples alu_done, or on the edge of the timeout.
- Timeout counter:
  - Cleared on CALC entry and incremented each CALC cycle.
  - ERROR is taken on the edge where it equals TIMEOUT.
  - If alu_done arrives on that same edge, alu_done wins.
- key_valid while busy, including the alu_done cycle, is dropped. There is no queue.
- Stray alu_done outside CALC is ignored.
- rst_n assertion mid-CALC forces N1 immediately:
  - alu_start = 0, busy = 0.
  - A later alu_done is ignored.

## Test plan
- Reset, then keys 1,2,+,3,= with alu_res = 0x0015 returned 3 cycles after alu_start:
  - alu_a = 0x0012, alu_b = 0x0003, alu_op = 0xC.
  - display = 0x0015 in SHOW, busy high 3 cycles.
- Chaining: keys 5,*,2,- gives CALC with op 0xE, then alu_res = 0x0010. Then keys 3,=:
  - second request has alu_a = 0x0010, alu_b = 0x0003, alu_op = 0xD.
- Entry limits, DIGITS = 4:
  - keys 0,0,1,2,3,4,5 gives num1 = 0x1234 (leading zeros and 5th digit ignored).
  - then AC gives num1 = 0.
  - AC in N2 with num2 = 0x0007 clears only num2; a second AC returns to N1 with num1 = 0.
- Error paths:
  - alu_done with alu_err = 1 gives disp_err = 1, display = 0.
  - With no alu_done for TIMEOUT = 8 cycles, ERROR is entered on cycle 8.
  - In ERROR, digits ignored; AC clears disp_err.
- Repeat-equals: after 2,+,3,= with res = 0x0005, pressing = again gives alu_a = 0x0005, alu_b = 0x0003, alu_op = 0xC.
- Busy and reset races:
  - key_valid during CALC and on the alu_done cycle is dropped (num2 unchanged).
  - rst_n low during CALC: all outputs 0, and a later alu_done is ignored.

Source files
------------

// File: rtl/calc_ctrl_fsm.sv
// ============================================================================
// Module   : calc_ctrl_fsm
// Brief    : Calculator control FSM - keypad entry, ALU handshake, display.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module calc_ctrl_fsm #(
  parameter int DIGITS  = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                key_valid,
  input  logic [3:0]          key_code,
  input  logic [4*DIGITS-1:0] alu_res,
  input  logic                alu_done,
  input  logic                alu_err,
  output logic [4*DIGITS-1:0] alu_a,
  output logic [4*DIGITS-1:0] alu_b,
  output logic [3:0]          alu_op,
  output logic                alu_start,
  output logic [4*DIGITS-1:0] display,
  output logic                disp_err,
  output logic                busy
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] C_MAX_CNT = CW'(DIGITS);
  localparam logic [TW-1:0] C_TMO     = TW'(TIMEOUT);

  typedef enum logic [2:0] {
    ST_N1    = 3'd0,
    ST_N2    = 3'd1,
    ST_CALC  = 3'd2,
    ST_SHOW  = 3'd3,
    ST_ERROR = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    num1_q, num1_d, num2_q, num2_d, res_q, res_d;
  logic [CW-1:0]   cnt1_q, cnt1_d, cnt2_q, cnt2_d;
  logic [3:0]      op_q, op_d, pend_op_q, pend_op_d;
  logic            chain_q, chain_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [W-1:0]    alu_a_q, alu_a_d, alu_b_q, alu_b_d, display_q, display_d;
  logic [3:0]      alu_op_q, alu_op_d;
  logic            alu_start_q, alu_start_d;

  logic            w_digit, w_eq, w_ac, w_oper, w_go_calc, w_clr_all, w_done;
  logic [W-1:0]    w_calc_a;

  // Leading zeros do not consume a digit slot; a full operand drops keys.
  function automatic logic [CW+W-1:0] enter_digit(input logic [W-1:0] x,
                                                  input logic [CW-1:0] c,
                                                  input logic [3:0] k);
    if (c == C_MAX_CNT || (k == 4'd0 && x == '0)) return {c, x};
    return {CW'(c + 1'b1), x[W-5:0], k};
  endfunction

  assign w_digit = key_valid && (key_code <= 4'd9);
  assign w_eq    = key_valid && (key_code == 4'hA);
  assign w_ac    = key_valid && (key_code == 4'hB);
  assign w_oper  = key_valid && (key_code >= 4'hC);
  // The alu_start cycle itself never samples alu_done.
  assign w_done  = alu_done && !alu_start_q;

  always_comb begin
    state_d     = state_q;
    num1_d      = num1_q;
    num2_d      = num2_q;
    res_d       = res_q;
    cnt1_d      = cnt1_q;
    cnt2_d      = cnt2_q;
    op_d        = op_q;
    pend_op_d   = pend_op_q;
    chain_d     = chain_q;
    tmo_d       = tmo_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    alu_start_d = 1'b0;
    w_go_calc   = 1'b0;
    w_clr_all   = 1'b0;
    w_calc_a    = num1_q;

    case (state_q)
      ST_N1: begin
        if (w_digit) begin
          {cnt1_d, num1_d} = enter_digit(num1_q, cnt1_q, key_code);
        end else if (w_oper) begin
          op_d    = key_code;
          num2_d  = '0;
          cnt2_d  = '0;
          state_d = ST_N2;
        end else if (w_ac) begin
          num1_d = '0;
          cnt1_d = '0;
        end
      end
      ST_N2: begin
        if (w_digit) begin
          {cnt2_d, num2_d} = enter_digit(num2_q, cnt2_q, key_code);
        end else if (w_oper) begin
          if (cnt2_q == '0) begin
            op_d = key_code;
          end else begin
            pend_op_d = key_code;
            chain_d   = 1'b1;
            w_go_calc = 1'b1;
          end
        end else if (w_eq && cnt2_q != '0) begin
          chain_d   = 1'b0;
          w_go_calc = 1'b1;
        end else if (w_ac) begin
          if (cnt2_q != '0) begin
            num2_d = '0;
            cnt2_d = '0;
          end else begin
            w_clr_all = 1'b1;
          end
        end
      end
      ST_CALC: begin
        tmo_d = tmo_q + 1'b1;
        if (w_done) begin
          if (alu_err) begin
            state_d = ST_ERROR;
          end else if (chain_q) begin
            num1_d  = alu_res;
            op_d    = pend_op_q;
            num2_d  = '0;
            cnt2_d  = '0;
            state_d = ST_N2;
          end else begin
            res_d   = alu_res;
            state_d = ST_SHOW;
          end
        end else if (tmo_d == C_TMO) begin
          state_d = ST_ERROR;
        end
      end
      ST_SHOW: begin
        if (w_digit) begin
          num1_d  = {{(W-4){1'b0}}, key_code};
          cnt1_d  = {{(CW-1){1'b0}}, key_code != 4'd0};
          num2_d  = '0;
          cnt2_d  = '0;
          state_d = ST_N1;
        end else if (w_oper) begin
          num1_d  = res_q;
          op_d    = key_code;
          num2_d  = '0;
          cnt2_d  = '0;
          state_d = ST_N2;
        end else if (w_eq) begin
          num1_d    = res_q;
          chain_d   = 1'b0;
          w_calc_a  = res_q;
          w_go_calc = 1'b1;
        end else if (w_ac) begin
          w_clr_all = 1'b1;
        end
      end
      ST_ERROR: begin
        if (w_ac) w_clr_all = 1'b1;
      end
      default: state_d = ST_N1;
    endcase

    if (w_go_calc) begin
      state_d     = ST_CALC;
      tmo_d       = '0;
      alu_start_d = 1'b1;
      alu_a_d     = w_calc_a;
      alu_b_d     = num2_q;
      alu_op_d    = op_q;
    end
    if (w_clr_all) begin
      state_d   = ST_N1;
      num1_d    = '0;
      num2_d    = '0;
      res_d     = '0;
      cnt1_d    = '0;
      cnt2_d    = '0;
      op_d      = '0;
      pend_op_d = '0;
      chain_d   = 1'b0;
    end

    case (state_q)
      ST_N1:   display_d = num1_q;
      ST_N2:   display_d = (cnt2_q != '0) ? num2_q : num1_q;
      ST_SHOW: display_d = res_q;
      ST_CALC: display_d = display_q;
      default: display_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_N1;
      num1_q      <= '0;
      num2_q      <= '0;
      res_q       <= '0;
      cnt1_q      <= '0;
      cnt2_q      <= '0;
      op_q        <= '0;
      pend_op_q   <= '0;
      chain_q     <= 1'b0;
      tmo_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      alu_start_q <= 1'b0;
      display_q   <= '0;
    end else begin
      state_q     <= state_d;
      num1_q      <= num1_d;
      num2_q      <= num2_d;
      res_q       <= res_d;
      cnt1_q      <= cnt1_d;
      cnt2_q      <= cnt2_d;
      op_q        <= op_d;
      pend_op_q   <= pend_op_d;
      chain_q     <= chain_d;
      tmo_q       <= tmo_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      alu_start_q <= alu_start_d;
      display_q   <= display_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign alu_start = alu_start_q;
  assign display   = display_q;
  assign disp_err  = (state_q == ST_ERROR);
  assign busy      = (state_q == ST_CALC);

endmodule

`default_nettype wire

// File: tb/tb_calc_ctrl_fsm.sv
// ============================================================================
// Module   : tb_calc_ctrl_fsm
// Brief    : Directed self-checking bench for calc_ctrl_fsm (DIGITS=4, TIMEOUT=8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_calc_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic [15:0] alu_res = 16'h0;
  logic        alu_done = 1'b0;
  logic        alu_err = 1'b0;
  logic [15:0] alu_a, alu_b, display;
  logic [3:0]  alu_op;
  logic        alu_start, disp_err, busy;

  int n_total = 0;
  int n_bad   = 0;
  int bc;

  calc_ctrl_fsm #(.DIGITS(4), .TIMEOUT(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
    .alu_res(alu_res), .alu_done(alu_done), .alu_err(alu_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
    .display(display), .disp_err(disp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Returns at the negedge after the key edge.
  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = k;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  // Called at the negedge of the alu_start cycle; alu_done is driven in cycle lat-1.
  task automatic reply(input logic [15:0] r, input logic e, input int lat, output int nb);
    nb = 0;
    for (int i = 0; i < lat; i++) begin
      if (busy) nb++;
      if (i == lat - 1) begin
        alu_done = 1'b1;
        alu_res  = r;
        alu_err  = e;
      end
      @(negedge clk);
    end
    alu_done = 1'b0;
    alu_err  = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_display", display, 0);
    check("rst_busy", busy, 0);
    check("rst_start", alu_start, 0);
    check("rst_err", disp_err, 0);
    check("rst_alu_a", alu_a, 0);
    rst_n = 1'b1;

    // 12 + 3 =
    press(4'h1); press(4'h2);
    @(negedge clk);
    check("n1_disp", display, 16'h0012);
    press(4'hC); press(4'h3);
    @(negedge clk);
    check("n2_disp", display, 16'h0003);
    press(4'hA);
    check("add_start", alu_start, 1);
    check("add_busy", busy, 1);
    check("add_a", alu_a, 16'h0012);
    check("add_b", alu_b, 16'h0003);
    check("add_op", alu_op, 4'hC);
    reply(16'h0015, 1'b0, 3, bc);
    check("add_busy_cycles", bc, 3);
    check("add_busy_low", busy, 0);
    check("add_start_low", alu_start, 0);
    @(negedge clk);
    check("show_disp", display, 16'h0015);

    // Chaining: 5 * 2 - -> result 0x10, then 3 =
    press(4'h5); press(4'hE); press(4'h2); press(4'hD);
    check("ch1_start", alu_start, 1);
    check("ch1_a", alu_a, 16'h0005);
    check("ch1_b", alu_b, 16'h0002);
    check("ch1_op", alu_op, 4'hE);
    reply(16'h0010, 1'b0, 2, bc);
    @(negedge clk);
    check("ch_n2_disp", display, 16'h0010);
    press(4'h3); press(4'hA);
    check("ch2_a", alu_a, 16'h0010);
    check("ch2_b", alu_b, 16'h0003);
    check("ch2_op", alu_op, 4'hD);
    reply(16'h000D, 1'b0, 2, bc);
    press(4'hB);

    // Entry limits and clear-entry
    press(4'h0); press(4'h0); press(4'h1); press(4'h2);
    press(4'h3); press(4'h4); press(4'h5);
    @(negedge clk);
    check("limit_disp", display, 16'h1234);
    press(4'hB);
    @(negedge clk);
    check("ac_n1_disp", display, 16'h0000);
    press(4'h1); press(4'hC); press(4'h7);
    @(negedge clk);
    check("ce_before", display, 16'h0007);
    press(4'hB);
    @(negedge clk);
    check("ce_after", display, 16'h0001);
    press(4'hB);
    @(negedge clk);
    check("ac2_disp", display, 16'h0000);
    press(4'h9);
    @(negedge clk);
    check("ac2_n1", display, 16'h0009);
    press(4'hB);

    // ALU error
    press(4'h8); press(4'hF); press(4'h0); press(4'h1); press(4'hA);
    reply(16'h0000, 1'b1, 2, bc);
    check("err_flag", disp_err, 1);
    @(negedge clk);
    check("err_disp", display, 16'h0000);
    press(4'h4);
    check("err_digit_flag", disp_err, 1);
    @(negedge clk);
    check("err_digit_disp", display, 16'h0000);
    press(4'hB);
    check("err_ac_flag", disp_err, 0);

    // Timeout: no alu_done
    press(4'h6); press(4'hC); press(4'h1); press(4'hA);
    bc = 0;
    for (int i = 0; i < 20 && busy; i++) begin
      bc++;
      @(negedge clk);
    end
    check("tmo_cycles", bc, 8);
    check("tmo_flag", disp_err, 1);
    press(4'hB);

    // Dropped keys in CALC and on the done cycle, then repeat-equals
    press(4'h2); press(4'hC); press(4'h3); press(4'hA);
    key_valid = 1'b1; key_code = 4'h7;
    @(negedge clk);
    key_code = 4'h9; alu_done = 1'b1; alu_res = 16'h0005;
    @(negedge clk);
    key_valid = 1'b0; alu_done = 1'b0;
    @(negedge clk);
    check("drop_show", display, 16'h0005);
    press(4'hA);
    check("rep_start", alu_start, 1);
    check("rep_a", alu_a, 16'h0005);
    check("rep_b", alu_b, 16'h0003);
    check("rep_op", alu_op, 4'hC);

    // Reset during CALC, then a stray alu_done
    rst_n = 1'b0;
    #1;
    check("rstc_start", alu_start, 0);
    check("rstc_busy", busy, 0);
    check("rstc_a", alu_a, 0);
    check("rstc_op", alu_op, 0);
    @(negedge clk);
    rst_n = 1'b1;
    alu_done = 1'b1; alu_res = 16'h0099;
    @(negedge clk);
    alu_done = 1'b0;
    @(negedge clk);
    check("stray_busy", busy, 0);
    check("stray_disp", display, 16'h0000);
    check("stray_err", disp_err, 0);
    press(4'h6);
    @(negedge clk);
    check("post_rst_n1", display, 16'h0006);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
